// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder/subtractor.
//   state_e    : sequencer states (IDLE, RUN, DONE)
//   BCD_MAX    : largest legal BCD digit value
//   BCD_ADJ    : correction added to a binary digit sum above BCD_MAX
//   nines_comp : nines complement of one 4-bit digit (wraps mod 16)
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

  // For digits above 9 the result wraps mod 16.
  // The digit adder then treats that wrapped value like any other digit.
  function automatic logic [3:0] nines_comp(input logic [3:0] d);
    return BCD_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit combinational BCD adder with carry.
//   a_d   in  4  augend digit
//   b_d   in  4  addend digit (already nines-complemented for subtract)
//   c_in  in  1  carry in
//   s_d   out 4  corrected result digit
//   c_out out 1  decimal carry out
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       c_in,
  output logic [3:0] s_d,
  output logic       c_out
);

  logic [4:0] t;

  always_comb begin
    t     = {1'b0, a_d} + {1'b0, b_d} + {4'b0, c_in};
    s_d   = t[3:0];
    c_out = 1'b0;
    if (t > {1'b0, BCD_MAX}) begin
      // Adding 6 and dropping bit 4 is the same as subtracting 10.
      s_d   = t[3:0] + BCD_ADJ;
      c_out = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Multi-digit BCD adder/subtractor processing one digit per clock, LSD first.
//   clk    in  1         rising-edge clock
//   rst_n  in  1         asynchronous active-low reset
//   start  in  1         request, honoured in IDLE or DONE
//   op_sub in  1         0 = add, 1 = subtract (ten's complement)
//   a, b   in  4*DIGITS  BCD operands, digit i at [4i+3:4i]
//   cin    in  1         carry-in (add) / borrow-in (subtract)
//   busy   out 1         digits being processed
//   done   out 1         one-cycle pulse, results valid from here on
//   sum    out 4*DIGITS  BCD result
//   cout   out 1         decimal carry out (add) / borrow out (subtract)
//   err    out 1         some latched operand digit was above 9
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op_sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic          sub_q, sub_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;
  logic [W-1:0]  res_q, res_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [3:0]    a_dig, b_raw, b_dig, s_dig;
  logic          c_nxt;
  logic          err_any;

  assign a_dig = opa_q[{idx_q, 2'b00} +: 4];
  assign b_raw = opb_q[{idx_q, 2'b00} +: 4];
  assign b_dig = sub_q ? nines_comp(b_raw) : b_raw;

  bcd_digit_add u_digit (
    .a_d   (a_dig),
    .b_d   (b_dig),
    .c_in  (carry_q),
    .s_d   (s_dig),
    .c_out (c_nxt)
  );

  always_comb begin
    err_any = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (opa_q[i*4 +: 4] > BCD_MAX || opb_q[i*4 +: 4] > BCD_MAX) begin
        err_any = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          sub_d   = op_sub;
          idx_d   = '0;
          // Subtract is a + nines(b) + 1 - borrow, so the borrow-in inverts.
          carry_d = op_sub ? ~cin : cin;
          res_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d[{idx_q, 2'b00} +: 4] = s_dig;
        carry_d = c_nxt;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST) begin
          // The outputs load from res_d so the last digit is included.
          sum_d   = res_d;
          cout_d  = sub_q ? ~c_nxt : c_nxt;
          err_d   = err_any;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule

// File: doc/bcd_addsub_serial.md
# bcd_addsub_serial

Parametrised multi-digit BCD adder/subtractor that processes one decimal digit per clock, least-significant digit first, behind a start/busy/done handshake. It generalises the single-digit combinational BCD add to DIGITS digits, adds a subtract mode (ten's-complement arithmetic with borrow) and flags non-BCD operand digits. It sits between operand registers and a result consumer in the decimal arithmetic datapath.

## Interface
- DIGITS, 4, number of BCD digits per operand and result; legal range 1 to 16.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op_sub  in  1  0 = add, 1 = subtract; latched on accepted start.
- a  in  4*DIGITS  operand A, digit i in bits [4i+3:4i]; latched on accepted start.
- b  in  4*DIGITS  operand B, same packing; latched on accepted start.
- cin  in  1  carry-in for add, borrow-in for subtract; latched on accepted start.
- busy  out  1  high while digits are being processed.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle on.
- sum  out  4*DIGITS  BCD result.
- cout  out  1  add: decimal carry out of the top digit. Sub: borrow out, 1 when a < b + cin.
- err  out  1  1 if any latched digit of a or b was greater than 9.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE: start=1 latches the operands, op_sub and cin. The digit index goes to 0, the carry register is set to (op_sub ? ~cin : cin), and the FSM moves to RUN.
- RUN: each cycle processes digit i.
  - b' = op_sub ? (9 − b_i) mod 16 : b_i.
  - t = a_i + b' + c, computed 5 bits wide, maximum 19.
  - If t > 9: digit = (t + 6)[3:0] and c = 1. Otherwise digit = t[3:0] and c = 0.
  - The digit is written into the internal result register and i increments.
  - After digit DIGITS−1 the FSM moves to DONE.
- DONE lasts one cycle.
  - sum takes the result register value.
  - cout = op_sub ? ~c : c.
  - err is the OR over all latched digits of (digit > 9).
  - done is 1.
  - start=1 in DONE is accepted exactly as in IDLE. Otherwise the FSM returns to IDLE.
- The err check is for flagging only: digits are computed by the same rule whether or not err is set.
- Subtract with borrow: sum is the ten's complement, for example 0001 − 0002 gives 9999 with cout = 1.
- sum, cout and err hold their value until the next DONE. They never show partial results.
- start while in RUN is ignored and has no side effects.
- op_sub, a, b and cin changing after acceptance have no effect.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, err=0, FSM=IDLE, digit index 0, carry 0.
- rst_n asserted mid-RUN aborts the operation immediately. No done is produced, and all outputs return to their reset values.
- Latency: start accepted in cycle 0, so busy is 1 in cycles 1 to DIGITS and done is 1 in cycle DIGITS+1.
- Throughput: one operation per DIGITS+1 cycles, with start held high or re-asserted in the DONE cycle.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package bcd_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - BCD_MAX = 9 and BCD_ADJ = 6;
  - a nines-complement function for a 4-bit digit.
- Sub-module bcd_digit_add is purely combinational:
  - inputs: a_d[3:0], b_d[3:0], c_in;
  - outputs: s_d[3:0], c_out;
  - it implements the t > 9 correction rule.
- The top level holds the FSM, operand shift/index logic, carry register and output registers.
- The digit index is $clog2(DIGITS) bits wide, with a minimum of 1 bit.

## Test plan
All scenarios use DIGITS=4, hex digits shown as BCD.
- Reset: hold rst_n=0 with random inputs, then release. Required: sum=0000, cout=0, err=0, busy=0, done=0, and nothing happens until start.
- Add with carry out: a=9999, b=0001, cin=0, op_sub=0, start at cycle 0. Required: busy in cycles 1–4, done at cycle 5, sum=0000, cout=1, err=0.
- Add with carry-in: a=0456, b=0789, cin=1. Required: sum=1246, cout=0.
- Subtract, no borrow: a=1000, b=0001, cin=0. Required: sum=0999, cout=0.
- Subtract, borrow: a=0001, b=0002. Required: sum=9999, cout=1.
- Handshake and reset:
  - A start pulse during RUN is ignored: exactly one done, and the second operand set is unused.
  - A start in the DONE cycle runs back-to-back, with the next done 5 cycles later.
  - rst_n=0 in RUN cycle 2 gives no done, and all outputs go to 0.
- Invalid digit: a=00A0, b=0000. Required: err=1, with sum following the digit rule (0100).
